csr_counter_reader: RTL and testbench

CSR_COUNTER_READER -- requirements
Module: csr_counter_reader

---
 rtl/csr_counter_reader_if.sv | 21 ++
 rtl/csr_counter_reader.sv | 120 ++++++++++++
 tb/tb_csr_counter_reader.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/csr_counter_reader_if.sv
// Request/response bus between a CSR requester and the 64-bit counter reader.
// The requester takes the master side; the reader takes the slave side.
interface csr_counter_reader_if;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_sel;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [63:0] rsp_data;
  logic        rsp_err;

  modport master (
    output req_valid, req_sel, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  req_valid, req_sel, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/csr_counter_reader.sv
// Tear-free 64-bit counter read over a 32-bit timer port (hi, lo, hi re-check).
// Latency 4 cycles accept->rsp_valid, +2 per retry; response held until rsp_ready.
module csr_counter_reader #(
  parameter int MAX_RETRY = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  csr_counter_reader_if.slave  bus,
  output logic [1:0]           tmr_sel,
  output logic                 tmr_upper,
  input  logic [31:0]          tmr_data
);

  localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam logic [RW-1:0] MAX_R = RW'(MAX_RETRY);

  typedef enum logic [2:0] {IDLE, RD_HI1, RD_LO, RD_HI2, RESP} state_e;

  state_e          state_q, state_d;
  logic [1:0]      sel_q, sel_d;
  logic [31:0]     hi_a_q, hi_a_d;
  logic [31:0]     lo_q, lo_d;
  logic [RW-1:0]   retry_q, retry_d;
  logic [63:0]     data_q, data_d;
  logic            err_q, err_d;

  logic            req_ready;
  logic            rsp_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= 2'd0;
      hi_a_q  <= 32'd0;
      lo_q    <= 32'd0;
      retry_q <= '0;
      data_q  <= 64'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      hi_a_q  <= hi_a_d;
      lo_q    <= lo_d;
      retry_q <= retry_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    hi_a_d    = hi_a_q;
    lo_d      = lo_q;
    retry_d   = retry_q;
    data_d    = data_q;
    err_d     = err_q;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    tmr_sel   = 2'd0;
    tmr_upper = 1'b0;

    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (bus.req_valid) begin
          sel_d = bus.req_sel;
          if (bus.req_sel == 2'd3) begin
            data_d  = 64'd0;
            err_d   = 1'b1;
            state_d = RESP;
          end else begin
            retry_d = '0;
            state_d = RD_HI1;
          end
        end
      end
      RD_HI1: begin
        tmr_sel   = sel_q;
        tmr_upper = 1'b1;
        hi_a_d    = tmr_data;
        state_d   = RD_LO;
      end
      RD_LO: begin
        tmr_sel = sel_q;
        lo_d    = tmr_data;
        state_d = RD_HI2;
      end
      RD_HI2: begin
        tmr_sel   = sel_q;
        tmr_upper = 1'b1;
        if (tmr_data == hi_a_q) begin
          data_d  = {hi_a_q, lo_q};
          err_d   = 1'b0;
          state_d = RESP;
        end else if (retry_q < MAX_R) begin
          // High word rolled over mid-read: the new high value pairs with a fresh low read.
          hi_a_d  = tmr_data;
          retry_d = retry_q + RW'(1);
          state_d = RD_LO;
        end else begin
          data_d  = 64'd0;
          err_d   = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.req_ready = req_ready;
  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_data  = rsp_valid ? data_q : 64'd0;
  assign bus.rsp_err   = rsp_valid ? err_q : 1'b0;

endmodule

// File: tb/tb_csr_counter_reader.sv
// Directed bench for csr_counter_reader: timer stub with scripted high words,
// transaction-level model for expected data/err/latency, per-cycle output checks.
module tb_csr_counter_reader;
  localparam int MAX_RETRY = 3;

  logic        clk;
  logic        rst;
  logic [1:0]  tmr_sel;
  logic        tmr_upper;
  logic [31:0] tmr_data;

  csr_counter_reader_if bus();

  csr_counter_reader #(.MAX_RETRY(MAX_RETRY)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .tmr_sel  (tmr_sel),
    .tmr_upper(tmr_upper),
    .tmr_data (tmr_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Timer stub: high word i-th read returns hi_seq[i], low word constant.
  logic [31:0] hi_seq [16];
  logic [31:0] stub_lo;
  logic [1:0]  cur_sel;
  int          hi_cnt;
  int          hi_base;
  int          hi_idx;

  initial hi_cnt = 0;
  always @(posedge clk) if (tmr_upper) hi_cnt <= hi_cnt + 1;

  always_comb begin
    hi_idx = hi_cnt - hi_base;
    if (hi_idx > 15) hi_idx = 15;
    if (hi_idx < 0) hi_idx = 0;
    if (tmr_sel != cur_sel) tmr_data = 32'hBAD0_0000;
    else if (tmr_upper)     tmr_data = hi_seq[hi_idx];
    else                    tmr_data = stub_lo;
  end

  int          n_tests;
  int          n_fail;
  int          cyc;
  int          acc_cyc;
  bit          chk_en;
  bit          txn_active;
  int          exp_lat;
  logic [63:0] exp_data;
  logic        exp_err;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Transaction-level reference: walk the high-word sequence with the retry rule.
  task automatic model(input logic [1:0] sel, input logic [31:0] lo,
                       output int lat, output logic [63:0] d, output logic e);
    logic [31:0] hi_a;
    logic [31:0] h;
    int k;
    int r;
    lat = 0; d = 64'd0; e = 1'b1;
    if (sel == 2'd3) begin
      lat = 1;
      return;
    end
    hi_a = hi_seq[0];
    k = 1;
    r = 0;
    while (k < 16) begin
      h = hi_seq[k];
      k++;
      if (h == hi_a) begin
        d = {hi_a, lo}; e = 1'b0; lat = 4 + 2 * r;
        return;
      end else if (r < MAX_RETRY) begin
        hi_a = h; r++;
      end else begin
        d = 64'd0; e = 1'b1; lat = 4 + 2 * r;
        return;
      end
    end
  endtask

  task automatic compare();
    int el;
    logic ev;
    if (!chk_en) return;
    if (!txn_active) begin
      chk("idle_req_ready", 64'(bus.req_ready), 64'd1);
      chk("idle_rsp_valid", 64'(bus.rsp_valid), 64'd0);
      chk("idle_tmr_upper", 64'(tmr_upper), 64'd0);
      chk("idle_tmr_sel", 64'(tmr_sel), 64'd0);
    end else begin
      el = cyc - acc_cyc + 1;
      ev = (el >= exp_lat);
      chk("busy_req_ready", 64'(bus.req_ready), 64'd0);
      chk("rsp_valid", 64'(bus.rsp_valid), 64'(ev));
      if (ev) begin
        chk("rsp_data", bus.rsp_data, exp_data);
        chk("rsp_err", 64'(bus.rsp_err), 64'(exp_err));
        chk("resp_tmr_upper", 64'(tmr_upper), 64'd0);
        chk("resp_tmr_sel", 64'(tmr_sel), 64'd0);
      end else begin
        chk("rd_tmr_upper", 64'(tmr_upper), 64'(el % 2 == 1));
        chk("rd_tmr_sel", 64'(tmr_sel), 64'(cur_sel));
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    compare();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Full request: hand-computed pins check the model, then the DUT is checked cycle by cycle.
  task automatic run_txn(input logic [1:0] sel, input logic [31:0] lo, input int hold,
                         input int pin_lat, input logic [63:0] pin_data, input logic pin_err);
    cur_sel = sel;
    stub_lo = lo;
    model(sel, lo, exp_lat, exp_data, exp_err);
    chk("model_lat", 64'(exp_lat), 64'(pin_lat));
    chk("model_data", exp_data, pin_data);
    chk("model_err", 64'(exp_err), 64'(pin_err));
    hi_base = hi_cnt;
    bus.req_valid = 1'b1;
    bus.req_sel   = sel;
    step();
    bus.req_valid = 1'b0;
    bus.req_sel   = 2'($urandom_range(0, 3));
    txn_active    = 1'b1;
    acc_cyc       = cyc;
    if (hold == 0) bus.rsp_ready = 1'b1;
    repeat (exp_lat - 1 + hold) step();
    bus.rsp_ready = 1'b1;
    step();
    bus.rsp_ready = 1'b0;
    txn_active    = 1'b0;
    step();
  endtask

  initial begin
    n_tests = 0; n_fail = 0; cyc = 0; acc_cyc = 0;
    chk_en = 1'b0; txn_active = 1'b0;
    exp_lat = 0; exp_data = 64'd0; exp_err = 1'b0;
    hi_base = 0; cur_sel = 2'd0; stub_lo = 32'd0;
    for (int i = 0; i < 16; i++) hi_seq[i] = 32'd0;
    bus.req_valid = 1'b0; bus.req_sel = 2'd0; bus.rsp_ready = 1'b0;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);
    chk("reset_rsp_data", bus.rsp_data, 64'd0);
    chk("reset_rsp_err", 64'(bus.rsp_err), 64'd0);
    step();

    // TIME with stable high word
    for (int i = 0; i < 16; i++) hi_seq[i] = 32'h1;
    run_txn(2'd1, 32'h12345678, 0, 4, 64'h0000_0001_1234_5678, 1'b0);

    // CYCLE high word rolls 4 -> 5 across the first low read
    hi_seq[0] = 32'h4;
    for (int i = 1; i < 16; i++) hi_seq[i] = 32'h5;
    run_txn(2'd0, 32'h3, 0, 6, 64'h0000_0005_0000_0003, 1'b0);

    // Invalid select
    run_txn(2'd3, 32'h0, 0, 1, 64'd0, 1'b1);

    // High word changes on every read: retry limit exhausted
    for (int i = 0; i < 16; i++) hi_seq[i] = 32'(i + 1);
    run_txn(2'd2, 32'hAAAA5555, 0, 10, 64'd0, 1'b1);

    // Response backpressure for 5 cycles
    for (int i = 0; i < 16; i++) hi_seq[i] = 32'h7;
    run_txn(2'd2, 32'hCAFEF00D, 5, 4, 64'h0000_0007_CAFE_F00D, 1'b0);

    // Reset while in RD_LO abandons the request
    for (int i = 0; i < 16; i++) hi_seq[i] = 32'h1;
    cur_sel = 2'd1; stub_lo = 32'h12345678; exp_lat = 4;
    hi_base = hi_cnt;
    bus.req_valid = 1'b1; bus.req_sel = 2'd1;
    step();
    bus.req_valid = 1'b0;
    txn_active = 1'b1; acc_cyc = cyc;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    txn_active = 1'b0;
    step();
    step();
    run_txn(2'd1, 32'h12345678, 0, 4, 64'h0000_0001_1234_5678, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish, cycle %0d", cyc);
    $fatal(1);
  end
endmodule
